// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_ctrl_pkg : shared codes, stall patterns and states for pipe_ctrl |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
package pipe_ctrl_pkg;

    localparam int         c_STALL_W    = 5;
    localparam int         c_EXC_W      = 5;
    localparam int         c_CNT_W      = 6;

    localparam logic       c_RST_ENABLE = 1'b0;
    localparam logic       c_STOP       = 1'b1;
    localparam logic       c_NOSTOP     = 1'b0;

    localparam logic [c_EXC_W-1:0] c_EXC_NONE = 5'h10;
    localparam logic [c_EXC_W-1:0] c_EXC_ERET = 5'h11;

    // Each pattern holds a prefix of stages; the register after the
    // highest held stage loads a bubble.
    localparam logic [c_STALL_W-1:0] c_STALL_NONE = 5'b00000;
    localparam logic [c_STALL_W-1:0] c_STALL_ID   = 5'b00111;
    localparam logic [c_STALL_W-1:0] c_STALL_DIV  = 5'b01111;
    localparam logic [c_STALL_W-1:0] c_STALL_ALL  = 5'b11111;

    typedef enum logic [1:0] {
        PC_RUN  = 2'd0,
        PC_DIV  = 2'd1,
        PC_DONE = 2'd2
    } pc_state_t;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_div_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_div_timer : divider latency down-counter with terminal flag      |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
module pipe_div_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_LAT = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_load,
    input  logic               i_dec,
    output logic [c_CNT_W-1:0] o_cnt,
    output logic               o_tc
);

    localparam logic [c_CNT_W-1:0] c_LOAD_VAL = c_CNT_W'(DIV_LAT - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == c_RST_ENABLE) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_LOAD_VAL;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == c_CNT_W'(1));

endmodule : pipe_div_timer
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_ctrl : pipeline stall/flush controller and divider sequencer     |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          STALL_W    = c_STALL_W,
    parameter int          DIV_LAT    = 32,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0100
) (
    input  logic               cpu_clk_50M,
    input  logic               cpu_rst_n,
    input  logic               stallreq_id,
    input  logic               stallreq_mem,
    input  logic               exe_div_req,
    input  logic [c_EXC_W-1:0] mem_exccode,
    input  logic [31:0]        cp0_epc,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [31:0]        flush_pc,
    output logic               div_start,
    output logic               div_done
);

    pc_state_t          r_state;
    logic [c_CNT_W-1:0] w_cnt;
    logic               w_tc;
    logic               w_exc;
    logic               w_div_start;
    logic               w_div_busy;
    logic [c_STALL_W-1:0] w_stall;

    assign w_exc       = (mem_exccode != c_EXC_NONE);
    assign w_div_start = (r_state == PC_RUN) && exe_div_req && !w_exc;
    assign w_div_busy  = (r_state == PC_DIV) || ((r_state == PC_RUN) && exe_div_req);

    pipe_div_timer #(
        .DIV_LAT (DIV_LAT)
    ) u_timer (
        .clk     (cpu_clk_50M),
        .rst_n   (cpu_rst_n),
        .i_clear (w_exc),
        .i_load  (w_div_start),
        .i_dec   (r_state == PC_DIV),
        .o_cnt   (w_cnt),
        .o_tc    (w_tc)
    );

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (cpu_rst_n == c_RST_ENABLE) begin
            r_state <= PC_RUN;
        end else if (w_exc) begin
            r_state <= PC_RUN;
        end else begin
            case (r_state)
                PC_RUN:  if (exe_div_req)   r_state <= PC_DIV;
                PC_DIV:  if (w_tc)          r_state <= PC_DONE;
                // The divide leaves EXE only once MEM is able to advance.
                PC_DONE: if (!stallreq_mem) r_state <= PC_RUN;
                default:                    r_state <= PC_RUN;
            endcase
        end
    end

    // An exception outranks every stall source.
    always_comb begin
        w_stall = c_STALL_NONE;
        if (!w_exc) begin
            if (stallreq_mem)
                w_stall = c_STALL_ALL;
            else if (w_div_busy)
                w_stall = c_STALL_DIV;
            else if (stallreq_id)
                w_stall = c_STALL_ID;
        end
    end

    assign stall     = STALL_W'(w_stall);
    assign flush     = w_exc;
    assign flush_pc  = !w_exc                      ? 32'h0000_0000 :
                       (mem_exccode == c_EXC_ERET) ? cp0_epc       : EXC_VECTOR;
    assign div_start = w_div_start;
    // A divide in flight when the pipe is flushed is discarded.
    assign div_done  = (r_state == PC_DONE) && !w_exc;

    logic w_unused;
    assign w_unused = ^w_cnt;

endmodule : pipe_ctrl
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_ctrl : randomized bench for pipe_ctrl with a cycle-age model  |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_pipe_ctrl;

    localparam int          c_LAT    = 4;
    localparam logic [31:0] c_VECTOR = 32'h0000_0100;
    localparam logic [4:0]  c_NONE   = 5'h10;
    localparam logic [4:0]  c_ERET   = 5'h11;

    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst_n   = 1'b0;
    logic        stallreq_id = 1'b0;
    logic        stallreq_mem = 1'b0;
    logic        exe_div_req = 1'b0;
    logic [4:0]  mem_exccode = c_NONE;
    logic [31:0] cp0_epc     = 32'h0;
    logic [4:0]  stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        div_start;
    logic        div_done;

    int n_vec  = 0;
    int n_fail = 0;
    // Cycles elapsed since the divide's start cycle; -1 when no divide.
    int age    = -1;

    pipe_ctrl #(
        .STALL_W    (5),
        .DIV_LAT    (c_LAT),
        .EXC_VECTOR (c_VECTOR)
    ) dut (
        .cpu_clk_50M  (cpu_clk_50M),
        .cpu_rst_n    (cpu_rst_n),
        .stallreq_id  (stallreq_id),
        .stallreq_mem (stallreq_mem),
        .exe_div_req  (exe_div_req),
        .mem_exccode  (mem_exccode),
        .cp0_epc      (cp0_epc),
        .stall        (stall),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .div_start    (div_start),
        .div_done     (div_done)
    );

    always #10 cpu_clk_50M = ~cpu_clk_50M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check against the model, then advance it.
    task automatic step(input logic id, input logic mem, input logic dv,
                        input logic [4:0] exc, input logic [31:0] epc);
        logic [4:0]  e_stall;
        logic [31:0] e_pc;
        logic        e_start, e_done, busy;
        @(negedge cpu_clk_50M);
        stallreq_id  = id;
        stallreq_mem = mem;
        exe_div_req  = dv;
        mem_exccode  = exc;
        cp0_epc      = epc;
        #1;
        if (exc != c_NONE) begin
            e_stall = 5'b0;
            e_pc    = (exc == c_ERET) ? epc : c_VECTOR;
            e_start = 1'b0;
            e_done  = 1'b0;
        end else begin
            e_start = (age < 0) && dv;
            busy    = e_start || (age >= 1 && age < c_LAT);
            e_done  = (age >= c_LAT);
            e_pc    = 32'h0;
            e_stall = mem ? 5'b11111 : busy ? 5'b01111 : id ? 5'b00111 : 5'b00000;
        end
        chk("stall",     32'(stall),     32'(e_stall));
        chk("flush",     32'(flush),     32'(exc != c_NONE));
        chk("flush_pc",  flush_pc,       e_pc);
        chk("div_start", 32'(div_start), 32'(e_start));
        chk("div_done",  32'(div_done),  32'(e_done));
        if (exc != c_NONE)           age = -1;
        else if (age < 0)            age = dv ? 1 : -1;
        else if (age < c_LAT)        age = age + 1;
        else if (!mem)               age = -1;
    endtask

    initial begin
        logic [4:0] rexc;
        // Outputs held low while reset is asserted.
        #5;
        chk("rst_stall", 32'(stall),     32'h0);
        chk("rst_flush", 32'(flush),     32'h0);
        chk("rst_start", 32'(div_start), 32'h0);
        chk("rst_done",  32'(div_done),  32'h0);
        @(negedge cpu_clk_50M);
        cpu_rst_n = 1'b1;
        step(0, 0, 0, c_NONE, 0);

        // Load-use stall for two cycles.
        step(1, 0, 0, c_NONE, 0);
        step(1, 0, 0, c_NONE, 0);
        step(0, 0, 0, c_NONE, 0);

        // Plain divide: request held until the done cycle.
        for (int i = 0; i < 5; i++) step(0, 0, 1, c_NONE, 0);
        step(0, 0, 0, c_NONE, 0);

        // Divide with a data-bus stall over cycles 2..6.
        for (int i = 0; i < 7; i++) step(0, (i >= 2), 1, c_NONE, 0);
        step(0, 0, 1, c_NONE, 0);
        step(0, 0, 0, c_NONE, 0);

        // ERET arriving while the divider runs.
        step(0, 0, 1, c_NONE, 0);
        step(0, 0, 1, c_NONE, 0);
        step(0, 0, 1, c_ERET, 32'h8000_0040);
        for (int i = 0; i < 6; i++) step(0, 0, 0, c_NONE, 0);

        // Exception with every stall request raised at once.
        step(1, 1, 0, 5'h04, 32'h1234_5678);
        step(0, 0, 0, c_NONE, 0);

        // Asynchronous reset in the middle of a divide.
        step(0, 0, 1, c_NONE, 0);
        step(0, 0, 0, c_NONE, 0);
        @(negedge cpu_clk_50M);
        #3 cpu_rst_n = 1'b0;
        #1;
        chk("arst_stall", 32'(stall),    32'h0);
        chk("arst_done",  32'(div_done), 32'h0);
        age = -1;
        @(negedge cpu_clk_50M);
        cpu_rst_n = 1'b1;
        step(0, 0, 0, c_NONE, 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 49))
                0:       rexc = c_ERET;
                1:       rexc = 5'h04;
                2:       rexc = 5'($urandom_range(0, 15));
                default: rexc = c_NONE;
            endcase
            step(($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0),
                 ($urandom_range(0, 2) == 0), rexc, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_pipe_ctrl
`default_nettype wire
